// File: rtl/batcharger_ctrl.sv
// Li-ion charge-mode controller: IDLE/TC/CC/CV/END sequencing from ADC codes,
// with debounced threshold transitions, CV timeout and registered mode outputs.
module batcharger_ctrl #(
  parameter logic [7:0]  VCUTOFF   = 8'd170,
  parameter logic [7:0]  VPRESET   = 8'd238,
  parameter logic [7:0]  VRECHARGE = 8'd230,
  parameter logic [7:0]  TMIN      = 8'd20,
  parameter logic [7:0]  TMAX      = 8'd230,
  parameter int unsigned DEB       = 4,
  parameter logic [15:0] CVTMAX    = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] vtemp,
  output logic       tc,
  output logic       cc,
  output logic       cv,
  output logic       imen,
  output logic       vmen,
  output logic       done,
  output logic [7:0] iref
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = CVTMAX - TMR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_END} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             tc_nx, cc_nx, cv_nx, imen_nx, vmen_nx, done_nx;
  logic [7:0]       iref_nx;

  logic [4:0] k;
  logic [7:0] k8;
  logic [7:0] k8_lim;
  logic       tok;
  logic       cond;
  state_t     exit_to;

  assign k      = 5'(sel) + 5'd1;
  assign k8     = {k, 3'b000};
  assign k8_lim = (k8 > 8'd128) ? 8'd128 : k8;
  assign tok    = (vtemp >= TMIN) && (vtemp <= TMAX);

  // State register, debounce counter, CV timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      tmr   <= '0;
      tc    <= 1'b0;
      cc    <= 1'b0;
      cv    <= 1'b0;
      imen  <= 1'b0;
      vmen  <= 1'b0;
      done  <= 1'b0;
      iref  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tmr   <= tmr_nx;
      tc    <= tc_nx;
      cc    <= cc_nx;
      cv    <= cv_nx;
      imen  <= imen_nx;
      vmen  <= vmen_nx;
      done  <= done_nx;
      iref  <= iref_nx;
    end
  end

  // Next-state: abort first, then IDLE entry, then debounced exits / CV timeout
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    tmr_nx   = '0;
    cond     = 1'b0;
    exit_to  = S_IDLE;
    unique case (state)
      S_TC:    begin cond = (vbat >= VCUTOFF);      exit_to = S_CC;   end
      S_CC:    begin cond = (vbat >= VPRESET);      exit_to = S_CV;   end
      S_CV:    begin cond = (ibat <= 8'(k));        exit_to = S_END;  end
      S_END:   begin cond = (vbat < VRECHARGE);     exit_to = S_IDLE; end
      default: begin cond = 1'b0;                   exit_to = S_IDLE; end
    endcase

    if (state == S_IDLE) begin
      if (en && tok) begin
        if (vbat < VCUTOFF)      state_nx = S_TC;
        else if (vbat < VPRESET) state_nx = S_CC;
        else                     state_nx = S_CV;
      end
    end else if (!en || !tok) begin
      state_nx = S_IDLE;
    end else begin
      if (cond) begin
        if (cnt == CNT_LAST) state_nx = exit_to;
        else                 cnt_nx   = cnt + CNT_W'(1);
      end
      if (state == S_CV) begin
        if (tmr == TMR_LAST) state_nx = S_END;
        else                 tmr_nx   = tmr + TMR_W'(1);
      end
      if (state_nx != state) begin
        cnt_nx = '0;
        tmr_nx = '0;
      end
    end
  end

  // Output decode from the next state
  always_comb begin
    tc_nx   = 1'b0;
    cc_nx   = 1'b0;
    cv_nx   = 1'b0;
    imen_nx = 1'b0;
    vmen_nx = 1'b0;
    done_nx = 1'b0;
    iref_nx = '0;
    unique case (state_nx)
      S_TC:    begin tc_nx = 1'b1; imen_nx = 1'b1; iref_nx = 8'(k);  end
      S_CC:    begin cc_nx = 1'b1; imen_nx = 1'b1; iref_nx = k8_lim; end
      S_CV:    begin cv_nx = 1'b1; vmen_nx = 1'b1; iref_nx = k8;     end
      S_END:   begin done_nx = 1'b1; end
      default: begin end
    endcase
  end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Self-checking bench for batcharger_ctrl: directed charge-cycle scenarios plus
// randomized stimulus checked every edge against a mode/streak reference model.
module tb_batcharger_ctrl;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] sel;
  logic [7:0] vbat, ibat, vtemp;
  logic       tc, cc, cv, imen, vmen, done;
  logic [7:0] iref;

  int n_checks = 0;
  int n_fail   = 0;

  batcharger_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .vbat(vbat), .ibat(ibat),
    .vtemp(vtemp), .tc(tc), .cc(cc), .cv(cv), .imen(imen), .vmen(vmen),
    .done(done), .iref(iref)
  );

  always #5 clk = ~clk;

  // Reference model: charging phase, length of the current qualifying streak,
  // and cycles spent in CV since entry.
  localparam int M_IDLE = 0, M_TC = 1, M_CC = 2, M_CV = 3, M_END = 4;
  int m_mode = M_IDLE;
  int m_streak = 0;
  int m_cvtime = 0;
  int m_iref = 0;

  function automatic logic [13:0] expect_vec();
    logic [7:0] ir;
    ir = 8'(m_iref);
    return {m_mode == M_TC, m_mode == M_CC, m_mode == M_CV,
            m_mode == M_TC || m_mode == M_CC, m_mode == M_CV, m_mode == M_END, ir};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {tc, cc, cv, imen, vmen, done, iref};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_streak = 0; m_cvtime = 0; m_iref = 0;
  endtask

  task automatic model_edge();
    int  k;
    bit  tempok, qual;
    int  nxt;
    k      = int'(sel) + 1;
    tempok = (vtemp >= 20) && (vtemp <= 230);
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode != M_IDLE && (!en || !tempok)) begin
      m_mode = M_IDLE; m_streak = 0; m_cvtime = 0;
    end else if (m_mode == M_IDLE) begin
      if (en && tempok) begin
        m_mode = (vbat < 170) ? M_TC : (vbat < 238) ? M_CC : M_CV;
        m_streak = 0; m_cvtime = 0;
      end
    end else begin
      case (m_mode)
        M_TC:    begin qual = vbat >= 170; nxt = M_CC;   end
        M_CC:    begin qual = vbat >= 238; nxt = M_CV;   end
        M_CV:    begin qual = ibat <= k;   nxt = M_END;  end
        default: begin qual = vbat < 230;  nxt = M_IDLE; end
      endcase
      m_streak = qual ? m_streak + 1 : 0;
      if (m_mode == M_CV) m_cvtime++;
      if (m_streak >= 4 || (m_mode == M_CV && m_cvtime >= 1000)) begin
        m_mode = nxt; m_streak = 0; m_cvtime = 0;
      end
    end
    case (m_mode)
      M_TC:         m_iref = k;
      M_CC:         m_iref = (k * 8 > 128) ? 128 : k * 8;
      M_CV:         m_iref = k * 8;
      default:      m_iref = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance model with the sampled inputs, then compare
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, 32'(dut_vec()), 32'(expect_vec()));
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 4'd0; vbat = 8'd0; ibat = 8'd200; vtemp = 8'd100;
    model_reset();
    steps(2, "reset");
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 1'b0;

    // 1: enter trickle
    en = 1'b1; vtemp = 8'd100; vbat = 8'd100; sel = 4'd8;
    step("tc_entry");
    chk("tc_flag", 32'(tc), 32'd1);
    chk("tc_imen", 32'(imen), 32'd1);
    chk("tc_iref", 32'(iref), 32'd9);

    // 2: broken streak then full debounce into CC
    vbat = 8'd170; steps(3, "tc_run1");
    vbat = 8'd169; step("tc_break");
    vbat = 8'd170; steps(3, "tc_run2");
    chk("tc_not_yet_cc", 32'(cc), 32'd0);
    step("tc_to_cc");
    chk("cc_flag", 32'(cc), 32'd1);
    chk("cc_iref", 32'(iref), 32'd72);

    // 3: CC -> CV -> END on termination current
    vbat = 8'd238; steps(4, "cc_to_cv");
    chk("cv_flags", 32'({cv, vmen}), 32'h3);
    chk("cv_iref", 32'(iref), 32'd72);
    ibat = 8'd9; steps(4, "cv_to_end");
    chk("end_vec", 32'(dut_vec()), 32'h0100);

    // 6: recharge threshold boundary
    vbat = 8'd231; steps(5, "end_hold");
    chk("end_hold_done", 32'(done), 32'd1);
    vbat = 8'd229; steps(4, "end_to_idle");
    chk("idle_vec", 32'(dut_vec()), 32'd0);
    step("idle_to_cc");
    chk("recharge_cc", 32'(cc), 32'd1);
    chk("recharge_iref", 32'(iref), 32'd72);

    // 4: CV timeout at exactly 1000 edges
    vbat = 8'd238; ibat = 8'd50; steps(4, "cc_to_cv2");
    chk("cv2_flag", 32'(cv), 32'd1);
    steps(999, "cv_timer");
    chk("cv_999_not_done", 32'(done), 32'd0);
    step("cv_timeout");
    chk("cv_1000_done", 32'(done), 32'd1);

    // 5: temperature abort, re-entry and async reset
    vbat = 8'd229; steps(4, "end_to_idle2");
    step("idle_to_cc2");
    vtemp = 8'd10; step("temp_abort");
    chk("abort_vec", 32'(dut_vec()), 32'd0);
    vtemp = 8'd100; vbat = 8'd200; step("reentry_cc");
    chk("reentry_cc_flag", 32'(cc), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_vec", 32'(dut_vec()), 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_held_vec", 32'(dut_vec()), 32'd0);

    // Randomized phase, with sticky values so debounce streaks can complete
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      else if (!en && $urandom_range(0, 99) < 30) en = 1'b1;
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 5))
          0:       vtemp = 8'd19;
          1:       vtemp = 8'd20;
          2:       vtemp = 8'd230;
          3:       vtemp = 8'd231;
          4:       vtemp = 8'($urandom_range(0, 255));
          default: vtemp = 8'd100;
        endcase
      end else if (vtemp < 20 || vtemp > 230) begin
        if ($urandom_range(0, 99) < 40) vtemp = 8'd120;
      end
      if ($urandom_range(0, 99) < 15) begin
        case ($urandom_range(0, 7))
          0: vbat = 8'd169;
          1: vbat = 8'd170;
          2: vbat = 8'd237;
          3: vbat = 8'd238;
          4: vbat = 8'd229;
          5: vbat = 8'd230;
          default: vbat = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 99) < 10) ibat = 8'(int'(sel) + $urandom_range(0, 3) - 1);
      else if ($urandom_range(0, 99) < 5) ibat = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 3) sel = 4'($urandom_range(0, 15));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
